// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;
  localparam int DIV_LATENCY    = DEF_DIVIDEND_W;

  localparam logic [DEF_DIVIDEND_W-1:0] DIV_ZERO_QUOTIENT = {DEF_DIVIDEND_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference or restore.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted_s;
  logic [DIVISOR_W+1:0] trial_s;

  // Trial subtraction; a set top bit means the divisor did not fit.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    trial_s   = shifted_s - {2'b00, divisor};
    if (trial_s[DIVISOR_W+1]) begin
      rem_out = shifted_s[DIVISOR_W:0];
      q_bit   = 1'b0;
    end else begin
      rem_out = trial_s[DIVISOR_W:0];
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per enabled clock.
// Optional signed operation is compiled in with DIV_SIGNED_EN.
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  div_state_e            state_r;
  logic [DIVIDEND_W-1:0] dvd_r;
  logic [DIVISOR_W-1:0]  dvs_r;
  logic [DIVISOR_W:0]    rem_r;
  logic [CNT_W-1:0]      cnt_r;

  logic [DIVISOR_W:0]    rem_next_s;
  logic                  q_bit_s;
  logic [DIVIDEND_W-1:0] q_raw_s;
  logic [DIVISOR_W-1:0]  r_raw_s;
  logic [DIVIDEND_W-1:0] q_fix_s;
  logic [DIVISOR_W-1:0]  r_fix_s;
  logic [DIVIDEND_W-1:0] dvd_mag_s;
  logic [DIVISOR_W-1:0]  dvs_mag_s;

  // The dividend register doubles as the quotient shift register.
  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[DIVIDEND_W-1]),
    .divisor (dvs_r),
    .rem_out (rem_next_s),
    .q_bit   (q_bit_s)
  );

  // Final-iteration result as it will look after this edge.
  always_comb begin
    q_raw_s = {dvd_r[DIVIDEND_W-2:0], q_bit_s};
    r_raw_s = rem_next_s[DIVISOR_W-1:0];
  end

`ifdef DIV_SIGNED_EN
  logic neg_q_r;
  logic neg_r_r;

  // Magnitudes feed the unsigned core; signs are reapplied at completion.
  always_comb begin
    if (dividend[DIVIDEND_W-1]) begin
      dvd_mag_s = -dividend;
    end else begin
      dvd_mag_s = dividend;
    end
    if (divisor[DIVISOR_W-1]) begin
      dvs_mag_s = -divisor;
    end else begin
      dvs_mag_s = divisor;
    end
    if (neg_q_r) begin
      q_fix_s = -q_raw_s;
    end else begin
      q_fix_s = q_raw_s;
    end
    if (neg_r_r) begin
      r_fix_s = -r_raw_s;
    end else begin
      r_fix_s = r_raw_s;
    end
  end

  // Operand signs captured alongside the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (en && (state_r == IDLE) && start) begin
      neg_q_r <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
      neg_r_r <= dividend[DIVIDEND_W-1];
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    dvd_mag_s = dividend;
    dvs_mag_s = divisor;
    q_fix_s   = q_raw_s;
    r_fix_s   = r_raw_s;
  end
`endif

  // Control FSM, iteration counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      dvd_r       <= {DIVIDEND_W{1'b0}};
      dvs_r       <= {DIVISOR_W{1'b0}};
      rem_r       <= {(DIVISOR_W+1){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      quotient    <= {DIVIDEND_W{1'b0}};
      remainder   <= {DIVISOR_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (en) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == {DIVISOR_W{1'b0}}) begin
              state_r     <= DONE;
              quotient    <= {DIVIDEND_W{1'b1}};
              remainder   <= {DIVISOR_W{1'b0}};
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              state_r <= CALC;
              dvd_r   <= dvd_mag_s;
              dvs_r   <= dvs_mag_s;
              rem_r   <= {(DIVISOR_W+1){1'b0}};
              cnt_r   <= CNT_W'(DIVIDEND_W - 1);
            end
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          dvd_r <= q_raw_s;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r     <= DONE;
            quotient    <= q_fix_s;
            remainder   <= r_fix_s;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued at start
// and compared on each rising done; latency and busy width are measured.
module tb_seq_divider;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int          vec_cnt = 0;
  int          miss_cnt = 0;
  int          done_events = 0;
  logic [24:0] sb_q[$];
  logic [24:0] exp_v;
  logic        done_q = 1'b0;

  int          lat;
  int          busy_cyc;
  int          done_cyc;
  int          ev0;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
    int qi;
    int ri;
    if (b == 8'd0) return {DIV_ZERO_QUOTIENT, 8'h00, 1'b1};
`ifdef DIV_SIGNED_EN
    qi = int'($signed(a)) / int'($signed(b));
    ri = int'($signed(a)) % int'($signed(b));
`else
    qi = int'(a) / int'(b);
    ri = int'(a) % int'(b);
`endif
    return {qi[15:0], ri[7:0], 1'b0};
  endfunction

  // Scoreboard: one pop per rising edge of done.
  always @(negedge clk) begin
    if (done && !done_q) begin
      done_events++;
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_v = sb_q.pop_front();
        check_eq("quotient", quotient, exp_v[24:9]);
        check_eq("remainder", remainder, exp_v[8:1]);
        check_eq("div_by_zero", div_by_zero, exp_v[0]);
      end
    end
    done_q = done;
  end

  task automatic do_div(input logic [15:0] a, input logic [7:0] b,
                        output int l, output int bc, output int dc);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    l  = -1;
    bc = 0;
    dc = 0;
    for (int j = 0; j < 60; j++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        if (l < 0) l = j;
      end
      if (!busy) break;
      @(posedge clk); #1;
    end
    check_eq("idle_after_op", busy, 32'd0);
  endtask

  task automatic timed_div(input logic [15:0] a, input logic [7:0] b);
    do_div(a, b, lat, busy_cyc, done_cyc);
    if (b == 8'd0) begin
      check_eq("dbz_latency", lat, 32'd0);
      check_eq("dbz_busy_cycles", busy_cyc, 32'd1);
    end else begin
      check_eq("latency", lat, DIV_LATENCY);
      check_eq("busy_cycles", busy_cyc, DIV_LATENCY + 1);
    end
    check_eq("done_width", done_cyc, 32'd1);
  endtask

  initial begin
    logic [15:0] va[5];
    logic [7:0]  vb[5];
    va = '{16'd1000, 16'd65535, 16'd65535, 16'd500, 16'd12};
    vb = '{8'd7, 8'd255, 8'd1, 8'd0, 8'd5};

    rst = 1'b1; en = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_quotient", quotient, 32'd0);
    check_eq("rst_remainder", remainder, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_done", done, 32'd0);
    check_eq("rst_dbz", div_by_zero, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    timed_div(16'd91, 8'd7);
    for (int i = 0; i < 5; i++) begin
      timed_div(va[i], vb[i]);
    end
    check_eq("q_12_5", quotient, 32'd2);
    check_eq("r_12_5", remainder, 32'd2);

    // Reset in the middle of a divide; nothing is queued for it.
    dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_quotient", quotient, 32'd0);
    check_eq("midrst_remainder", remainder, 32'd0);
    check_eq("midrst_busy", busy, 32'd0);
    check_eq("midrst_done", done, 32'd0);
    check_eq("midrst_dbz", div_by_zero, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    timed_div(16'd100, 8'd9);

    // Extra starts while busy and an enable gap of three cycles.
    ev0 = done_events;
    dividend = 16'd91; divisor = 8'd7; start = 1'b1;
    sb_q.push_back(model(16'd91, 8'd7));
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    done_cyc = 0;
    for (int j = 0; j < 60; j++) begin
      if (done) begin
        done_cyc++;
        if (lat < 0) lat = j;
      end
      if (!busy && j > 0) break;
      start = (j == 3 || j == 10) ? 1'b1 : 1'b0;
      if (start) begin
        dividend = 16'd5;
        divisor  = 8'd1;
      end
      if (j == 4) en = 1'b0;
      if (j == 7) en = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_eq("stretched_latency", lat, 32'd19);
    check_eq("stretched_done_width", done_cyc, 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_eq("no_queued_start", busy, 32'd0);
    check_eq("single_completion", done_events - ev0, 32'd1);

`ifdef DIV_SIGNED_EN
    timed_div(16'hFFA5, 8'd7);
    check_eq("s_q_m91_7", quotient, 32'h0000FFF3);
    timed_div(16'hFF9C, 8'd7);
    check_eq("s_q_m100_7", quotient, 32'h0000FFF2);
    check_eq("s_r_m100_7", remainder, 32'h000000FE);
    timed_div(16'd100, 8'hF9);
    check_eq("s_q_100_m7", quotient, 32'h0000FFF2);
    check_eq("s_r_100_m7", remainder, 32'd2);
`endif

    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider: the inverse datapath to the board's shift-add multiplier. It takes a 16-bit dividend and an 8-bit divisor and produces a 16-bit quotient and an 8-bit remainder, one quotient bit per clock. It sits beside the multiplier behind the same wrapper:
- start comes from the debounced BTNC pulse.
- Results feed the product/seven-segment display path, selected by the wrapper.

## Interface
Parameters:
- DIVIDEND_W, 16, dividend and quotient width; also the iteration count.
- DIVISOR_W, 8, divisor and remainder width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  single-cycle start pulse; sampled only in IDLE with en=1.
- dividend  in  DIVIDEND_W  numerator; sampled on the start edge.
- divisor  in  DIVISOR_W  denominator; sampled on the start edge.
- quotient  out  DIVIDEND_W  result; registered.
- remainder  out  DIVISOR_W  result; registered.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse when quotient/remainder are updated.
- div_by_zero  out  1  set with done when divisor=0; held until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC: on start & en with divisor != 0.
  - Latches operands.
  - Clears the partial remainder (DIVISOR_W+1 bits).
  - Sets bit counter to DIVIDEND_W-1.
- IDLE -> DONE: on start & en with divisor == 0.
  - Writes quotient = all ones, remainder = 0, div_by_zero = 1.
- CALC, each enabled edge:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep the difference and shift in a quotient bit of 1; otherwise restore and shift in 0.
  - Decrement the counter.
  - At counter 0, go to DONE and write quotient/remainder/div_by_zero=0.
- DONE: done=1 for this cycle; next enabled edge -> IDLE.
- start while busy: ignored (no queueing).
- Outputs hold the last result until the next DONE entry.
- Reset values: quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, state=IDLE.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values; the partial result is discarded.
- Invariants:
  - remainder < divisor always holds for divisor != 0.
  - quotient*divisor + remainder == dividend.

## Timing
- Start sampled at edge 0:
  - busy high from cycle after edge 0.
  - Outputs written at edge DIVIDEND_W (16).
  - done high in cycle 16–17 only.
  - busy falls after edge 17.
- Divide-by-zero: outputs and done valid in the cycle after edge 0 (latency 1).
- en low for N cycles during CALC/DONE stretches latency by exactly N; done stays high until the first enabled edge after it asserts.
- rst has priority over en and start.

## Configuration
- DIV_SIGNED_EN defined:
  - Operands are two's complement.
  - Magnitudes are divided by the same unsigned core.
  - Quotient is truncated toward zero and negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Divide-by-zero gives quotient = all ones, remainder = 0.
  - Sign fix-up is registered at the DONE entry; latency is unchanged.
- DIV_SIGNED_EN undefined: purely unsigned; no sign logic synthesized.

## Structure
- Package div_pkg:
  - state enum (IDLE/CALC/DONE).
  - DIVIDEND_W/DIVISOR_W defaults.
  - DIV_LATENCY = DIVIDEND_W.
  - DIV_ZERO_QUOTIENT constant (all ones).
- Sub-module div_step: combinational shift/trial-subtract/restore for one bit.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
- Top: FSM, counter, operand registers, output registers, optional sign logic.

## Test plan
- 91 / 7 after reset:
  - quotient=13, remainder=0.
  - done exactly 16 cycles after the start edge, one cycle wide; busy high for 17 cycles.
- 1000 / 7 -> quotient=142, remainder=6; then 65535 / 255 -> 257, 0; then 65535 / 1 -> 65535, 0.
- 500 / 0:
  - done after 1 cycle, div_by_zero=1, quotient=16'hFFFF, remainder=0.
  - A following 12 / 5 -> 2, 2 with div_by_zero=0.
- 91 / 7 with extra start pulses at cycles 3 and 10, and en=0 for cycles 5–7:
  - Single result 13/0; done at cycle 19; extra starts ignored.
- 1000 / 7 with rst asserted at cycle 8:
  - All outputs 0 and busy=0 next cycle.
  - A new 100 / 9 then gives 11, 1.
- DIV_SIGNED_EN:
  - -91 / 7 -> quotient=16'hFFF3, remainder=0.
  - -100 / 7 -> quotient=-14 (16'hFFF2), remainder=-2 (8'hFE).
  - 100 / -7 -> quotient=-14, remainder=2.
